imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
Shares the single instruction-memory port between the instruction fetch path and a secondary data/loader requester (program loading, literal-pool reads, debug access). One outstanding memory transaction at a time; variable-latency memory signalled by mem_ready. Fixed priority to the data requester, with a starvation limit that forces a fetch grant, and cancellation of in-flight fetches on pipeline flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive fetch denials before fetch is forced to win (1..15)
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
f_req  input  1  fetch request, held until granted or withdrawn
f_addr  input  ADDR_W  fetch address
f_cancel  input  1  flush: cancel pending/in-flight fetch
f_gnt  output  1  fetch request accepted (1-cycle pulse)
f_rdata  output  DATA_W  fetch read data
f_rvalid  output  1  fetch data valid (1-cycle pulse)
d_req  input  1  data requester request
d_addr  input  ADDR_W  data address
d_we  input  1  1=write, 0=read
d_wdata  input  DATA_W  write data
d_gnt  output  1  data request accepted (1-cycle pulse)
d_rdata  output  DATA_W  data read data
d_rvalid  output  1  read data valid / write ack (1-cycle pulse)
mem_addr  output  ADDR_W  memory address
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_wdata  output  DATA_W  memory write data
mem_data  input  DATA_W  memory read data
mem_ready  input  1  memory completes current access
busy  output  1  transaction outstanding (state != IDLE)
owner  output  1  0=fetch, 1=data; valid while busy

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; all outputs 0; starve_cnt=0. Applies mid-transaction; any later mem_ready is ignored.
- States: IDLE, BUSY, DROP.
- IDLE arbitration (combinational gnt): d_req wins unless (f_req && !f_cancel && starve_cnt>=STARVE_LIMIT); otherwise f_req && !f_cancel wins. The winner's gnt is high this cycle; the edge latches addr/we/wdata, owner and mem_read/mem_write (registered), and goes to BUSY.
- starve_cnt: +1 (saturating at 15) on each IDLE cycle where f_req && !f_cancel is denied because d wins; cleared on f_gnt; unchanged otherwise.
- BUSY: mem_* held stable until mem_ready. On mem_ready: drop strobes next edge, register mem_data into owner's rdata (writes return 0), pulse owner's rvalid the cycle after mem_ready, go to IDLE. mem_ready in IDLE/DROP outside a transaction is ignored.
- Latency: gnt at cycle 0, strobe high cycles 1..k (mem_ready at k), rvalid at k+1. A new grant can occur in cycle k+1 (IDLE), so strobes are back-to-back with a one-cycle gap.
- f_cancel while BUSY with owner=fetch: go to DROP. The strobe stays asserted until mem_ready (the memory cannot abort), then return to IDLE with no f_rvalid. f_cancel does not affect data transactions.
- f_cancel and mem_ready in the same BUSY cycle: the fetch is dropped, with no f_rvalid.
- rdata outputs hold their last value between rvalid pulses.

Optional Feature:
IMEM_ARB_TIMEOUT_EN
- Defined: adds output timeout_err (1 bit, sticky, cleared by rst) and a cycle counter in BUSY/DROP. If mem_ready is absent for TIMEOUT_CYCLES cycles, the arbiter:
  - deasserts the strobes;
  - pulses the owner's rvalid with rdata=0 (none in DROP);
  - sets timeout_err;
  - returns to IDLE.
- Undefined: no counter and no timeout_err port; the arbiter waits indefinitely.

Test Plan:
- Reset: hold rst 2 cycles with d_req=f_req=1 -> all outputs 0, no gnt, busy=0.
- Fetch read: f_req, f_addr=0x100, mem_ready 3 cycles after strobe with mem_data=0xDEADBEEF -> f_gnt cycle 0, mem_read=1 with mem_addr=0x100 cycles 1-3, f_rvalid with f_rdata=0xDEADBEEF cycle 4.
- Contention: f_req and d_req both held, mem_ready=1 each strobe cycle -> d granted 4 times, then fetch forced on the 5th grant, starve_cnt back to 0.
- Cancel: fetch in BUSY, f_cancel pulse, mem_ready 2 cycles later -> mem_read held until mem_ready, no f_rvalid, IDLE afterwards, pending d_req granted next.
- Data write: d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_write=1 with those values until mem_ready, d_rvalid pulse with d_rdata=0.
- Timeout (IMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): fetch, mem_ready never asserted -> strobe dropped after 8 cycles, f_rvalid with f_rdata=0, timeout_err=1 until rst.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one instruction-memory port between the fetch path
// and a data/loader requester. One transaction in flight at a time; the data side
// has fixed priority, but a starvation counter forces a fetch grant once fetch has
// lost STARVE_LIMIT times in a row. A flushed fetch is allowed to finish on the
// memory side and its data is discarded.
// Optional build macro: IMEM_ARB_TIMEOUT_EN adds a watchdog and a sticky timeout_err.
module imem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_cancel,
    output logic              f_gnt,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_rvalid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic              busy,
    output logic              owner
`ifdef IMEM_ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic        w_f_valid;
    logic        w_f_force;
    logic        w_f_gnt;
    logic        w_d_gnt;
    logic        w_drop_now;
    logic        w_finish;
    logic        w_tmo_hit;

    // A fetch only competes when it is not being flushed in the same cycle.
    assign w_f_valid = f_req && !f_cancel;
    assign w_f_force = w_f_valid && (r_starve_cnt >= 4'(STARVE_LIMIT));

    // The fetch result is discarded if it was flushed earlier or is flushed now.
    assign w_drop_now = (r_state == S_DROP) ||
                        ((r_state == S_BUSY) && !owner && f_cancel);
    assign w_finish   = (r_state != S_IDLE) && (mem_ready || w_tmo_hit);

    assign f_gnt = w_f_gnt;
    assign d_gnt = w_d_gnt;
    assign busy  = (r_state != S_IDLE);

`ifdef IMEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Last waiting cycle before the watchdog gives up on the memory.
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && !mem_ready;

    // Watchdog: counts cycles spent waiting on the memory, latches a sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            if (w_finish && w_tmo_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    // No watchdog: constant low for any legal limit, so the arbiter waits on mem_ready.
    assign w_tmo_hit = (TIMEOUT_CYCLES == 0);
`endif

    // Arbitration and next-state selection.
    always_comb begin
        w_f_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rst) begin
                    w_state_nxt = S_IDLE;
                end else if (d_req && !w_f_force) begin
                    w_d_gnt     = 1'b1;
                    w_state_nxt = S_BUSY;
                end else if (w_f_valid) begin
                    w_f_gnt     = 1'b1;
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY, S_DROP: begin
                if (w_finish) begin
                    w_state_nxt = S_IDLE;
                end else if (w_drop_now) begin
                    w_state_nxt = S_DROP;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, latched request, memory strobes, responses and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 4'd0;
            mem_addr     <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_wdata    <= '0;
            owner        <= 1'b0;
            f_rdata      <= '0;
            f_rvalid     <= 1'b0;
            d_rdata      <= '0;
            d_rvalid     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (w_d_gnt) begin
                mem_addr  <= d_addr;
                mem_read  <= !d_we;
                mem_write <= d_we;
                mem_wdata <= d_wdata;
                owner     <= 1'b1;
                if (w_f_valid && (r_starve_cnt != 4'd15)) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else if (w_f_gnt) begin
                mem_addr     <= f_addr;
                mem_read     <= 1'b1;
                mem_write    <= 1'b0;
                mem_wdata    <= '0;
                owner        <= 1'b0;
                r_starve_cnt <= 4'd0;
            end else if (w_finish) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                if (!w_drop_now) begin
                    if (owner) begin
                        d_rvalid <= 1'b1;
                        d_rdata  <= (mem_write || w_tmo_hit) ? '0 : mem_data;
                    end else begin
                        f_rvalid <= 1'b1;
                        f_rdata  <= w_tmo_hit ? '0 : mem_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: transaction-level model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_imem_port_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 8;
`ifdef IMEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_cancel, f_gnt, f_rvalid;
    logic [31:0] f_addr, f_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_data;
    logic        mem_read, mem_write, mem_ready, busy, owner;
`ifdef IMEM_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    imem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_cancel(f_cancel), .f_gnt(f_gnt),
        .f_rdata(f_rdata), .f_rvalid(f_rvalid),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_data(mem_data), .mem_ready(mem_ready),
        .busy(busy), .owner(owner)
`ifdef IMEM_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // State describes what the outputs must be during the next clock cycle.
    bit          m_valid = 1'b0;
    bit          m_busy, m_data, m_we, m_cancel, m_zero, m_terr;
    bit          m_frv, m_drv;
    logic [31:0] m_addr, m_wdata, m_frd, m_drd;
    int          m_starve, m_wait;

    task automatic m_complete(input logic [31:0] rd);
        m_busy = 1'b0;
        if (!m_cancel) begin
            if (m_data) begin
                m_drv = 1'b1;
                m_drd = m_we ? 32'h0 : rd;
            end else begin
                m_frv = 1'b1;
                m_frd = rd;
            end
        end
    endtask

    // Compare process: check DUT against model, then advance model to the next cycle.
    always @(negedge clk) begin
        bit fv, exp_fg, exp_dg;
        fv     = f_req && !f_cancel;
        exp_fg = 1'b0;
        exp_dg = 1'b0;
        if (!rst && !m_busy) begin
            if (d_req && !(fv && m_starve >= STARVE)) exp_dg = 1'b1;
            else if (fv)                              exp_fg = 1'b1;
        end
        if (m_valid) begin
            check("mdl_f_gnt",     32'(f_gnt),     32'(exp_fg));
            check("mdl_d_gnt",     32'(d_gnt),     32'(exp_dg));
            check("mdl_busy",      32'(busy),      32'(m_busy));
            check("mdl_mem_read",  32'(mem_read),  32'(m_busy && !m_we));
            check("mdl_mem_write", 32'(mem_write), 32'(m_busy && m_we));
            check("mdl_f_rvalid",  32'(f_rvalid),  32'(m_frv));
            check("mdl_d_rvalid",  32'(d_rvalid),  32'(m_drv));
            check("mdl_f_rdata",   f_rdata,        m_frd);
            check("mdl_d_rdata",   d_rdata,        m_drd);
            if (m_busy) begin
                check("mdl_mem_addr", mem_addr,    m_addr);
                check("mdl_owner",    32'(owner),  32'(m_data));
                if (m_we) check("mdl_mem_wdata", mem_wdata, m_wdata);
            end
            if (m_zero) begin
                check("mdl_rst_addr",  mem_addr,   32'h0);
                check("mdl_rst_wdata", mem_wdata,  32'h0);
                check("mdl_rst_owner", 32'(owner), 32'h0);
            end
`ifdef IMEM_ARB_TIMEOUT_EN
            check("mdl_timeout_err", 32'(timeout_err), 32'(m_terr));
`endif
        end
        if (rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_cancel = 1'b0; m_zero = 1'b1;
            m_terr = 1'b0;  m_frv = 1'b0;  m_drv = 1'b0;
            m_frd = 32'h0;  m_drd = 32'h0; m_starve = 0; m_wait = 0;
            m_data = 1'b0;  m_we = 1'b0;   m_addr = 32'h0; m_wdata = 32'h0;
        end else if (m_valid) begin
            m_frv = 1'b0;
            m_drv = 1'b0;
            if (!m_busy) begin
                if (exp_dg) begin
                    m_busy = 1'b1; m_data = 1'b1; m_addr = d_addr; m_we = d_we;
                    m_wdata = d_wdata; m_cancel = 1'b0; m_wait = 0; m_zero = 1'b0;
                    if (fv) m_starve = (m_starve >= 15) ? 15 : m_starve + 1;
                end else if (exp_fg) begin
                    m_busy = 1'b1; m_data = 1'b0; m_addr = f_addr; m_we = 1'b0;
                    m_cancel = 1'b0; m_wait = 0; m_zero = 1'b0; m_starve = 0;
                end
            end else begin
                if (!m_data && f_cancel) m_cancel = 1'b1;
                m_wait++;
                if (mem_ready) begin
                    m_complete(mem_data);
                end else if (TMO_EN && m_wait == TMO) begin
                    m_complete(32'h0);
                    m_terr = 1'b1;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int  nd;
        bit  found;
        rst = 1'b1; f_req = 1'b1; d_req = 1'b1; f_cancel = 1'b0; d_we = 1'b0;
        f_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_data = 32'h0; mem_ready = 1'b0;

        // Reset held with both requests active: no grants, nothing busy.
        tick; tick;
        @(negedge clk);
        check("rst_f_gnt",    32'(f_gnt),    32'h0);
        check("rst_d_gnt",    32'(d_gnt),    32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_mem_read", 32'(mem_read), 32'h0);
        tick;
        rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
        tick; tick;

        // Fetch read with a 3-cycle memory.
        f_req = 1'b1; f_addr = 32'h100;
        @(negedge clk); check("fetch_gnt", 32'(f_gnt), 32'h1);
        tick; f_req = 1'b0;
        @(negedge clk);
        check("fetch_strobe", 32'(mem_read), 32'h1);
        check("fetch_addr",   mem_addr,      32'h100);
        tick;
        tick; mem_ready = 1'b1; mem_data = 32'hDEADBEEF;
        @(negedge clk); check("fetch_strobe_c3", 32'(mem_read), 32'h1);
        tick; mem_ready = 1'b0; mem_data = 32'h0;
        @(negedge clk);
        check("fetch_rvalid", 32'(f_rvalid), 32'h1);
        check("fetch_rdata",  f_rdata,       32'hDEADBEEF);
        check("fetch_strobe_off", 32'(mem_read), 32'h0);
        tick; tick;

        // Contention: data wins STARVE times, then fetch is forced.
        f_req = 1'b1; d_req = 1'b1; f_addr = 32'h300; d_addr = 32'h200; d_we = 1'b0;
        mem_ready = 1'b1; mem_data = 32'h55;
        nd = 0; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (d_gnt) nd++;
            if (f_gnt) found = 1'b1;
        end
        check("contention_fetch_seen", 32'(found), 32'h1);
        check("contention_d_grants",   32'(nd),    32'd4);
        repeat (10) tick;
        f_req = 1'b0; d_req = 1'b0;
        repeat (3) tick;
        mem_ready = 1'b0;
        tick;

        // Cancel an in-flight fetch; pending data request goes next.
        f_req = 1'b1; f_addr = 32'h400;
        @(negedge clk); check("cancel_f_gnt", 32'(f_gnt), 32'h1);
        tick; f_req = 1'b0; d_req = 1'b1; d_addr = 32'h500; d_we = 1'b0;
        @(negedge clk); check("cancel_d_wait", 32'(d_gnt), 32'h0);
        tick; f_cancel = 1'b1;
        tick; f_cancel = 1'b0;
        @(negedge clk); check("cancel_strobe_held", 32'(mem_read), 32'h1);
        tick; mem_ready = 1'b1; mem_data = 32'hBAD;
        tick; mem_ready = 1'b0;
        @(negedge clk);
        check("cancel_no_rvalid", 32'(f_rvalid), 32'h0);
        check("cancel_rdata_hold", f_rdata,      32'h55);
        check("cancel_d_gnt",     32'(d_gnt),    32'h1);
        tick; d_req = 1'b0; f_cancel = 1'b1; mem_ready = 1'b1; mem_data = 32'h77;
        tick; f_cancel = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("data_ignores_cancel", 32'(d_rvalid), 32'h1);
        check("data_rdata",          d_rdata,       32'h77);
        tick;

        // Cancel and mem_ready in the same cycle.
        f_req = 1'b1; f_addr = 32'h600;
        tick; f_req = 1'b0; f_cancel = 1'b1; mem_ready = 1'b1; mem_data = 32'h99;
        tick; f_cancel = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("cancel_ready_no_rvalid", 32'(f_rvalid), 32'h0);
        check("cancel_ready_idle",      32'(busy),     32'h0);
        tick;

        // Data write.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        @(negedge clk); check("write_gnt", 32'(d_gnt), 32'h1);
        tick; d_req = 1'b0;
        @(negedge clk);
        check("write_strobe", 32'(mem_write), 32'h1);
        check("write_noread", 32'(mem_read),  32'h0);
        check("write_addr",   mem_addr,       32'h40);
        check("write_wdata",  mem_wdata,      32'h12345678);
        check("write_owner",  32'(owner),     32'h1);
        tick; mem_ready = 1'b1; mem_data = 32'hFFFFFFFF;
        tick; mem_ready = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check("write_ack",   32'(d_rvalid), 32'h1);
        check("write_rdata", d_rdata,       32'h0);

        // Stray mem_ready while idle is ignored.
        tick; mem_ready = 1'b1;
        repeat (3) tick;
        mem_ready = 1'b0;
        tick;

        // Reset in the middle of a fetch; the late mem_ready is ignored.
        f_req = 1'b1; f_addr = 32'h700;
        tick; f_req = 1'b0;
        tick; rst = 1'b1;
        tick; rst = 1'b0; mem_ready = 1'b1; mem_data = 32'hAA;
        @(negedge clk);
        check("midrst_no_rvalid", 32'(f_rvalid), 32'h0);
        check("midrst_idle",      32'(busy),     32'h0);
        check("midrst_rdata",     f_rdata,       32'h0);
        tick; mem_ready = 1'b0;
        tick;

        // Memory that never answers.
        f_req = 1'b1; f_addr = 32'h800; mem_data = 32'hCC;
        tick; f_req = 1'b0;
`ifdef IMEM_ARB_TIMEOUT_EN
        repeat (7) tick;
        @(negedge clk); check("tmo_strobe_c8", 32'(mem_read), 32'h1);
        tick;
        @(negedge clk);
        check("tmo_rvalid",    32'(f_rvalid),    32'h1);
        check("tmo_rdata",     f_rdata,          32'h0);
        check("tmo_strobe_off", 32'(mem_read),   32'h0);
        check("tmo_err",       32'(timeout_err), 32'h1);
        repeat (3) tick;
        @(negedge clk); check("tmo_err_sticky", 32'(timeout_err), 32'h1);
`else
        repeat (12) tick;
        @(negedge clk); check("no_tmo_still_busy", 32'(busy), 32'h1);
`endif
        tick; rst = 1'b1;
        tick; rst = 1'b0;
        @(negedge clk);
        check("final_idle", 32'(busy), 32'h0);
`ifdef IMEM_ARB_TIMEOUT_EN
        check("tmo_err_cleared", 32'(timeout_err), 32'h0);
`endif
        tick; tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
